// File: rtl/uc_multicycle.sv
// Multicycle MIPS control unit. A Moore FSM sequences fetch, decode, execute,
// memory and write-back. One 3-bit counter stretches the memory phases by
// MEM_LATENCY wait cycles. BRANCH folds the condition into PCLoad
// combinationally.
module uc_multicycle #(
  parameter int MEM_LATENCY = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCLoad,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       AWrite,
  output logic       BWrite,
  output logic       ALUOutWrite,
  output logic       EPCWrite,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [4:0] State
);

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  typedef enum logic [4:0] {
    S_FETCH      = 5'd0,
    S_FETCH_WAIT = 5'd1,
    S_DECODE     = 5'd2,
    S_RTYPE_EX   = 5'd3,
    S_RTYPE_WB   = 5'd4,
    S_ADDI_EX    = 5'd5,
    S_IMM_WB     = 5'd6,
    S_LUI        = 5'd7,
    S_BRANCH     = 5'd8,
    S_JUMP       = 5'd9,
    S_JAL        = 5'd10,
    S_JR         = 5'd11,
    S_MEM_ADDR   = 5'd12,
    S_LW_RD      = 5'd13,
    S_LW_WB      = 5'd14,
    S_SW_WR      = 5'd15,
    S_EXC        = 5'd16
  } state_t;

  state_t     r_state, w_next;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_run;    // low until the first edge after reset release
  logic       r_bne;    // branch flavour, captured in DECODE
  logic       r_sw;     // store vs load, captured in DECODE
  logic       w_last;   // final cycle of a memory phase
  logic       w_act;    // strobes allowed to fire
  logic       w_fn_ok;
  logic [2:0] w_fn_op;

  assign State = r_state;
  assign w_act = Reset & r_run;

  // Funct to ALU operation; unknown codes trap.
  always_comb begin
    w_fn_ok = 1'b1;
    w_fn_op = 3'b000;
    case (Funct)
      6'h20: w_fn_op = 3'b000;
      6'h22: w_fn_op = 3'b001;
      6'h24: w_fn_op = 3'b010;
      6'h25: w_fn_op = 3'b011;
      6'h26: w_fn_op = 3'b100;
      6'h2a: w_fn_op = 3'b101;
      default: w_fn_ok = 1'b0;
    endcase
  end

  // Last cycle of a memory phase. FETCH is last only when there are no wait
  // states; the wait states count down to zero.
  always_comb w_last = (r_state == S_FETCH) ? (LAT == 3'd0) : (r_cnt == 3'd0);

  // State, counter and the latched instruction-class bits. The first edge
  // after reset release only arms r_run, so that edge begins the first FETCH.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_FETCH;
      r_cnt   <= 3'd0;
      r_run   <= 1'b0;
      r_bne   <= 1'b0;
      r_sw    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        r_state <= w_next;
        r_cnt   <= w_cnt_nxt;
      end
      if (r_state == S_DECODE) begin
        r_bne <= Op[0];
        r_sw  <= Op[3];
      end
    end
  end

  // Next-state and wait-counter sequencing.
  always_comb begin
    w_next    = S_FETCH;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_FETCH: begin
        if (LAT == 3'd0) w_next = S_DECODE;
        else begin
          // FETCH is the first phase cycle, so the wait part lasts LAT cycles.
          w_next    = S_FETCH_WAIT;
          w_cnt_nxt = LAT - 3'd1;
        end
      end
      S_FETCH_WAIT: begin
        if (w_last) w_next = S_DECODE;
        else begin
          w_next    = S_FETCH_WAIT;
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_DECODE: begin
        case (Op)
          6'h00:        w_next = (Funct == 6'h08) ? S_JR : S_RTYPE_EX;
          6'h02:        w_next = S_JUMP;
          6'h03:        w_next = S_JAL;
          6'h04, 6'h05: w_next = S_BRANCH;
          6'h08:        w_next = S_ADDI_EX;
          6'h0f:        w_next = S_LUI;
          6'h23, 6'h2b: w_next = S_MEM_ADDR;
          default:      w_next = S_EXC;
        endcase
      end
      S_RTYPE_EX: w_next = w_fn_ok ? S_RTYPE_WB : S_EXC;
      S_ADDI_EX:  w_next = S_IMM_WB;
      S_MEM_ADDR: begin
        w_next    = r_sw ? S_SW_WR : S_LW_RD;
        w_cnt_nxt = LAT;
      end
      S_LW_RD: begin
        if (w_last) w_next = S_LW_WB;
        else begin
          w_next    = S_LW_RD;
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_SW_WR: begin
        if (w_last) w_next = S_FETCH;
        else begin
          w_next    = S_SW_WR;
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Moore control word per state. Irreversible strobes are masked in reset.
  always_comb begin
    PCLoad      = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MDRWrite    = 1'b0;
    AWrite      = 1'b0;
    BWrite      = 1'b0;
    ALUOutWrite = 1'b0;
    EPCWrite    = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 2'd0;
    RegDst      = 2'd0;
    PCSource    = 2'd0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = 3'b000;
    case (r_state)
      S_FETCH, S_FETCH_WAIT: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = w_last;
        PCLoad  = w_last;
      end
      S_DECODE: begin
        AWrite      = 1'b1;
        BWrite      = 1'b1;
        ALUOutWrite = 1'b1;
        ALUSrcB     = 2'b11;
      end
      S_RTYPE_EX: begin
        ALUSrcA     = 1'b1;
        ALUOp       = w_fn_op;
        ALUOutWrite = w_fn_ok;
      end
      S_RTYPE_WB: begin
        RegDst   = 2'd1;
        RegWrite = 1'b1;
      end
      S_ADDI_EX, S_MEM_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALUOutWrite = 1'b1;
      end
      S_IMM_WB: RegWrite = 1'b1;
      S_LUI: begin
        MemtoReg = 2'd2;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 3'b001;
        PCSource = 2'd1;
        PCLoad   = r_bne ? ~Zero : Zero;
      end
      S_JUMP: begin
        PCSource = 2'd2;
        PCLoad   = 1'b1;
      end
      S_JAL: begin
        PCSource = 2'd2;
        PCLoad   = 1'b1;
        RegDst   = 2'd2;
        MemtoReg = 2'd3;
        RegWrite = 1'b1;
      end
      S_JR: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b111;
        PCLoad  = 1'b1;
      end
      S_LW_RD: begin
        IorD     = 1'b1;
        MemRead  = 1'b1;
        MDRWrite = w_last;
      end
      S_LW_WB: begin
        MemtoReg = 2'd1;
        RegWrite = 1'b1;
      end
      S_SW_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXC: begin
        EPCWrite = 1'b1;
        PCSource = 2'd3;
        PCLoad   = 1'b1;
      end
      default: ;
    endcase
    if (!w_act) begin
      PCLoad   = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      EPCWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_uc_multicycle.sv
// Bench for uc_multicycle: three instances (latency 0, 2, 3) run directed
// and random instruction streams. A reference model expands each instruction
// into its expected per-cycle control words, which are queued when the
// instruction is issued. A per-lane monitor pops one word every cycle.
module tb_uc_multicycle;

  typedef struct packed {
    logic       pcl, iord, mrd, mwr, irw, mdrw, aw, bw, aow, epcw, rw;
    logic [1:0] m2r, rdst, pcs;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
  } ctl_t;
  typedef ctl_t cq_t[$];

  localparam int ND = 19;
  localparam int NI = ND + 40 + 2;

  logic gclk;
  int   nvec = 0;
  int   nmis = 0;
  logic [5:0] dop [ND];
  logic [5:0] dfn [ND];
  logic       dz  [ND];

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  initial begin
    dop = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03,
            6'h04, 6'h04, 6'h05, 6'h05, 6'h08, 6'h0f, 6'h23, 6'h2b, 6'h3f};
    dfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h01, 6'h08, 6'h00, 6'h00,
            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    dz  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  end

  // Expected control words for one whole instruction, phase by phase.
  function automatic cq_t model(input int L, input logic [5:0] op, input logic [5:0] fn,
                                input logic z);
    cq_t        e;
    ctl_t       t;
    logic       ok;
    logic [2:0] a;
    for (int i = 0; i <= L; i++) begin
      t = '0; t.mrd = 1'b1; t.srcb = 2'b01;
      if (i == L) begin t.irw = 1'b1; t.pcl = 1'b1; end
      e.push_back(t);
    end
    t = '0; t.aw = 1'b1; t.bw = 1'b1; t.aow = 1'b1; t.srcb = 2'b11;
    e.push_back(t);
    t = '0;
    if (op == 6'h00 && fn == 6'h08) begin
      t.srca = 1'b1; t.aluop = 3'b111; t.pcl = 1'b1;
      e.push_back(t);
    end else if (op == 6'h00) begin
      ok = 1'b1; a = 3'b000;
      case (fn)
        6'h20: a = 3'b000;
        6'h22: a = 3'b001;
        6'h24: a = 3'b010;
        6'h25: a = 3'b011;
        6'h26: a = 3'b100;
        6'h2a: a = 3'b101;
        default: ok = 1'b0;
      endcase
      t.srca = 1'b1; t.aluop = a; t.aow = ok;
      e.push_back(t);
      t = '0;
      if (ok) begin t.rdst = 2'd1; t.rw = 1'b1; end
      else begin t.epcw = 1'b1; t.pcs = 2'd3; t.pcl = 1'b1; end
      e.push_back(t);
    end else begin
      case (op)
        6'h02: begin t.pcs = 2'd2; t.pcl = 1'b1; e.push_back(t); end
        6'h03: begin
          t.pcs = 2'd2; t.pcl = 1'b1; t.rdst = 2'd2; t.m2r = 2'd3; t.rw = 1'b1;
          e.push_back(t);
        end
        6'h04, 6'h05: begin
          t.srca = 1'b1; t.aluop = 3'b001; t.pcs = 2'd1;
          t.pcl = (op == 6'h04) ? z : ~z;
          e.push_back(t);
        end
        6'h08: begin
          t.srca = 1'b1; t.srcb = 2'b10; t.aow = 1'b1; e.push_back(t);
          t = '0; t.rw = 1'b1; e.push_back(t);
        end
        6'h0f: begin t.m2r = 2'd2; t.rw = 1'b1; e.push_back(t); end
        6'h23, 6'h2b: begin
          t.srca = 1'b1; t.srcb = 2'b10; t.aow = 1'b1; e.push_back(t);
          for (int i = 0; i <= L; i++) begin
            t = '0; t.iord = 1'b1;
            if (op == 6'h23) begin t.mrd = 1'b1; t.mdrw = (i == L); end
            else t.mwr = 1'b1;
            e.push_back(t);
          end
          if (op == 6'h23) begin t = '0; t.m2r = 2'd1; t.rw = 1'b1; e.push_back(t); end
        end
        default: begin t.epcw = 1'b1; t.pcs = 2'd3; t.pcl = 1'b1; e.push_back(t); end
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    logic       rst_n, zero, done;
    logic [5:0] op, fn;
    logic       pcl, iord, mrd, mwr, irw, mdrw, aw, bw, aow, epcw, rw, srca;
    logic [1:0] m2r, rdst, pcs, srcb;
    logic [2:0] aluop;
    logic [4:0] st;
    ctl_t       act;
    ctl_t       q[$];

    assign act = {pcl, iord, mrd, mwr, irw, mdrw, aw, bw, aow, epcw, rw,
                  m2r, rdst, pcs, srca, srcb, aluop};

    uc_multicycle #(.MEM_LATENCY(L)) u_dut (
      .Clk(gclk), .Reset(rst_n), .Op(op), .Funct(fn), .Zero(zero),
      .PCLoad(pcl), .IorD(iord), .MemRead(mrd), .MemWrite(mwr), .IRWrite(irw),
      .MDRWrite(mdrw), .AWrite(aw), .BWrite(bw), .ALUOutWrite(aow),
      .EPCWrite(epcw), .RegWrite(rw), .MemtoReg(m2r), .RegDst(rdst),
      .PCSource(pcs), .ALUSrcA(srca), .ALUSrcB(srcb), .ALUOp(aluop), .State(st)
    );

    // Monitor: one expected word per cycle, sampled mid-cycle.
    initial begin
      ctl_t exp;
      forever begin
        @(negedge gclk);
        if (q.size() != 0) begin
          exp = q.pop_front();
          nvec++;
          if (act !== exp) begin
            nmis++;
            $display("FAIL ctl L=%0d: got %h want %h state %0d at %0t",
                     L, act, exp, st, $time);
          end
        end
      end
    end

    // Driver: issues instructions, queues their expected words, scrambles
    // Op/Funct/Zero in every cycle where they must be ignored.
    initial begin
      cq_t        e;
      ctl_t       rv;
      logic [5:0] o, f;
      logic       z;
      int         cut, len, k;
      done = 1'b0; rst_n = 1'b0; op = '0; fn = '0; zero = 1'b0;
      rv = '0; rv.mrd = 1'b1; rv.srcb = 2'b01;
      repeat (2) @(posedge gclk);
      #1 q.push_back(rv);
      @(negedge gclk);
      #1 rst_n = 1'b1;
      @(posedge gclk);
      for (int n = 0; n < NI; n++) begin
        cut = -1; z = 1'($urandom); f = 6'($urandom);
        if (n < ND) begin
          o = dop[n]; f = dfn[n]; z = dz[n];
        end else if (n == NI - 2) begin
          o = 6'h2b; cut = L + 3 + ((L > 0) ? 1 : 0);
        end else if (n == NI - 1) begin
          o = 6'h00; f = 6'h20;
        end else begin
          k = $urandom_range(0, 11);
          case (k)
            0, 1, 2: o = 6'h00;
            3: o = 6'h02;  4: o = 6'h03;  5: o = 6'h04;  6: o = 6'h05;
            7: o = 6'h08;  8: o = 6'h0f;  9: o = 6'h23;  10: o = 6'h2b;
            default: o = 6'($urandom);
          endcase
          if (o == 6'h00 && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 6))
              0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24; 3: f = 6'h25;
              4: f = 6'h26; 5: f = 6'h2a; default: f = 6'h08;
            endcase
          end
        end
        #1;
        e = model(L, o, f, z);
        len = (cut >= 0) ? cut : e.size();
        for (int c = 0; c < len; c++) begin
          if (c > 0) begin @(posedge gclk); #1; end
          q.push_back(e[c]);
          if (c == L + 1 || c == L + 2) begin op = o; fn = f; end
          else begin op = 6'($urandom); fn = 6'($urandom); end
          zero = (c == L + 2) ? z : 1'($urandom);
        end
        if (cut >= 0) begin
          // Abort the store mid-phase; the strobe must fall with reset.
          @(posedge gclk);
          #1 rst_n = 1'b0;
          q.push_back(rv);
          #1 chk($sformatf("rst_memwrite L=%0d", L), int'(mwr), 0);
          @(negedge gclk);
          #1 rst_n = 1'b1;
        end
        @(posedge gclk);
      end
      done = 1'b1;
    end
  end

  initial begin
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < 20000 && !fin; i++) begin
      @(posedge gclk);
      fin = lane[0].done && lane[1].done && lane[2].done;
    end
    if (!fin) begin
      nmis++;
      $display("FAIL timeout: lanes done %b%b%b want 111",
               lane[2].done, lane[1].done, lane[0].done);
    end
    repeat (2) @(negedge gclk);
    chk("drain L=0", lane[0].q.size(), 0);
    chk("drain L=2", lane[1].q.size(), 0);
    chk("drain L=3", lane[2].q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
